microcode_sequencer: RTL and testbench

Control unit for the 8-bit bus CPU. It sequences fetch/execute T-states from the instruction-register opcode and the ALU flags, and drives the 15-bit control word that the datapath top-level consumes. Datapath blocks sample the word on the rising clk edge. This block is the producer end of the control_signals interface.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/microcode_sequencer_if.sv | 23 ++
 rtl/microcode_rom.sv | 94 +++++++++
 rtl/microcode_sequencer.sv | 60 ++++++
 tb/tb_microcode_sequencer.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit bus CPU control unit: opcodes, control-word
// bit positions, the all-inactive control word and the T-state encoding.
package cpu_pkg;

  localparam int CW_W = 15;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CS_CP   = 14;
  localparam int CS_EP   = 13;
  localparam int CS_LP   = 12;
  localparam int CS_NLMA = 11;
  localparam int CS_NLMD = 10;
  localparam int CS_NCE  = 9;
  localparam int CS_NLR  = 8;
  localparam int CS_NLI  = 7;
  localparam int CS_NEI  = 6;
  localparam int CS_NLA  = 5;
  localparam int CS_EA   = 4;
  localparam int CS_SUB  = 3;
  localparam int CS_EU   = 2;
  localparam int CS_NLB  = 1;
  localparam int CS_NLO  = 0;

  // Active-low strobes parked high, active-high strobes parked low.
  localparam logic [CW_W-1:0] IDLE_WORD = 15'h0FE3;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

endpackage

// File: rtl/microcode_sequencer_if.sv
// Control-unit bundle: IR opcode and ALU flags in, control word and status out.
// The sequencer is the master (producer of the control word).
interface microcode_sequencer_if;
  import cpu_pkg::*;

  logic [3:0]      opcode;
  logic            cf;
  logic            zf;
  logic [CW_W-1:0] control_signals;
  logic [2:0]      t_state;
  logic            halted;

  modport master (
    input  opcode, cf, zf,
    output control_signals, t_state, halted
  );

  modport slave (
    output opcode, cf, zf,
    input  control_signals, t_state, halted
  );

endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode table: (step, opcode, flags) -> control word and a
// flag marking the last step of the current instruction.
module microcode_rom
  import cpu_pkg::*;
(
  input  step_e           step_i,
  input  logic [3:0]      opcode_i,
  input  logic            cf_i,
  input  logic            zf_i,
  output logic [CW_W-1:0] word_o,
  output logic            last_o
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    word_o = IDLE_WORD;
    last_o = 1'b1;
    case (step_i)
      T0: begin
        word_o[CS_EP]   = 1'b1;
        word_o[CS_NLMA] = 1'b0;
        last_o          = 1'b0;
      end
      T1: begin
        word_o[CS_CP]  = 1'b1;
        word_o[CS_NCE] = 1'b0;
        word_o[CS_NLI] = 1'b0;
        last_o         = 1'b0;
      end
      T2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            word_o[CS_NEI]  = 1'b0;
            word_o[CS_NLMA] = 1'b0;
            last_o          = 1'b0;
          end
          OP_LDI: begin
            word_o[CS_NEI] = 1'b0;
            word_o[CS_NLA] = 1'b0;
          end
          OP_JMP: begin
            word_o[CS_NEI] = 1'b0;
            word_o[CS_LP]  = 1'b1;
          end
          OP_JC: begin
            word_o[CS_NEI] = !cf_i;
            word_o[CS_LP]  = cf_i;
          end
          OP_JZ: begin
            word_o[CS_NEI] = !zf_i;
            word_o[CS_LP]  = zf_i;
          end
          OP_OUT: begin
            word_o[CS_EA]  = 1'b1;
            word_o[CS_NLO] = 1'b0;
          end
          default: ;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_LDA: begin
            word_o[CS_NCE] = 1'b0;
            word_o[CS_NLA] = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            word_o[CS_NCE] = 1'b0;
            word_o[CS_NLB] = 1'b0;
            last_o         = 1'b0;
          end
          OP_STA: begin
            word_o[CS_EA]   = 1'b1;
            word_o[CS_NLMD] = 1'b0;
            last_o          = 1'b0;
          end
          default: ;
        endcase
      end
      T4: begin
        case (opcode_i)
          OP_ADD, OP_SUB: begin
            word_o[CS_EU]  = 1'b1;
            word_o[CS_NLA] = 1'b0;
            word_o[CS_SUB] = (opcode_i == OP_SUB);
          end
          OP_STA: word_o[CS_NLR] = 1'b0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/microcode_sequencer.sv
// T-state sequencer for the bus CPU: step register, HALT flag and reset forcing
// around the combinational microcode table.
module microcode_sequencer
  import cpu_pkg::*;
#(
  parameter bit HLT_ENABLE = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  microcode_sequencer_if.master ctrl_if
);

  step_e           step_q, step_d;
  logic            halted_q, halted_d;
  logic [CW_W-1:0] rom_word;
  logic            rom_last;
  logic            hlt_now;

  microcode_rom u_rom (
    .step_i   (step_q),
    .opcode_i (ctrl_if.opcode),
    .cf_i     (ctrl_if.cf),
    .zf_i     (ctrl_if.zf),
    .word_o   (rom_word),
    .last_o   (rom_last)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign hlt_now = HLT_ENABLE && (step_q == T2) && (ctrl_if.opcode == OP_HLT);

  // HALT parks the counter on T2; T4 always wraps regardless of the table.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (hlt_now) begin
        halted_d = 1'b1;
      end else if (rom_last || step_q == T4) begin
        step_d = T0;
      end else begin
        step_d = step_e'(step_q + 3'd1);
      end
    end
  end

  assign ctrl_if.control_signals = (rst || halted_q) ? IDLE_WORD : rom_word;
  assign ctrl_if.t_state         = step_q;
  assign ctrl_if.halted          = halted_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed + randomized bench for microcode_sequencer, checked against a
// per-instruction word table taken straight from the instruction set.
module tb_microcode_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst0;

  always #5 clk = ~clk;

  microcode_sequencer_if bus1 ();
  microcode_sequencer_if bus0 ();

  microcode_sequencer #(.HLT_ENABLE(1'b1)) dut1 (.clk(clk), .rst(rst),  .ctrl_if(bus1));
  microcode_sequencer #(.HLT_ENABLE(1'b0)) dut0 (.clk(clk), .rst(rst0), .ctrl_if(bus0));

  int n_vec  = 0;
  int n_fail = 0;

  logic [14:0] exp_w [5];
  int          exp_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // sel=0 -> HLT_ENABLE=1 instance, sel=1 -> HLT_ENABLE=0 instance
  task automatic drive(input bit sel, input logic [3:0] op, input logic c, input logic z);
    if (sel) begin
      bus0.opcode = op; bus0.cf = c; bus0.zf = z;
    end else begin
      bus1.opcode = op; bus1.cf = c; bus1.zf = z;
    end
  endtask

  task automatic check_cycle(input bit sel, input string tag, input logic [14:0] ew,
                             input logic [2:0] et, input logic eh);
    logic [14:0] cs;
    logic [2:0]  ts;
    logic        h;
    int          drv;
    cs = sel ? bus0.control_signals : bus1.control_signals;
    ts = sel ? bus0.t_state : bus1.t_state;
    h  = sel ? bus0.halted  : bus1.halted;
    chk({tag, "_cw"}, 32'(cs), 32'(ew));
    chk({tag, "_tstate"}, 32'(ts), 32'(et));
    chk({tag, "_halted"}, 32'(h), 32'(eh));
    drv = int'(cs[13]) + int'(!cs[9]) + int'(!cs[6]) + int'(cs[4]) + int'(cs[2]);
    chk({tag, "_one_driver"}, 32'(drv <= 1), 32'd1);
  endtask

  // Reference: full control-word sequence of one instruction, fetch included.
  task automatic build_model(input logic [3:0] op, input logic c, input logic z);
    exp_w[0] = 15'h27E3;
    exp_w[1] = 15'h4D63;
    exp_w[2] = 15'h0FE3;
    exp_w[3] = 15'h0FE3;
    exp_w[4] = 15'h0FE3;
    exp_n    = 3;
    case (op)
      4'h1: begin exp_w[2] = 15'h07A3; exp_w[3] = 15'h0DC3; exp_n = 4; end
      4'h2: begin exp_w[2] = 15'h07A3; exp_w[3] = 15'h0DE1; exp_w[4] = 15'h0FC7; exp_n = 5; end
      4'h3: begin exp_w[2] = 15'h07A3; exp_w[3] = 15'h0DE1; exp_w[4] = 15'h0FCF; exp_n = 5; end
      4'h4: begin exp_w[2] = 15'h07A3; exp_w[3] = 15'h0BF3; exp_w[4] = 15'h0EE3; exp_n = 5; end
      4'h5: exp_w[2] = 15'h0F83;
      4'h6: exp_w[2] = 15'h1FA3;
      4'h7: exp_w[2] = c ? 15'h1FA3 : 15'h0FE3;
      4'h8: exp_w[2] = z ? 15'h1FA3 : 15'h0FE3;
      4'hE: exp_w[2] = 15'h0FF2;
      default: ;
    endcase
  endtask

  // Entered with the DUT in T0 and away from a clock edge. Opcode is garbage
  // during fetch; flags are random everywhere except T2.
  task automatic run_instr(input bit sel, input logic [3:0] op, input logic c, input logic z,
                           input int abort_at);
    string tag;
    build_model(op, c, z);
    for (int k = 0; k < exp_n; k++) begin
      if (k == 2)     drive(sel, op, c, z);
      else if (k < 2) drive(sel, 4'($urandom), 1'($urandom), 1'($urandom));
      else            drive(sel, op, 1'($urandom), 1'($urandom));
      #1;
      tag = $sformatf("%s_op%h_T%0d", sel ? "hlt0" : "hlt1", op, k);
      check_cycle(sel, tag, exp_w[k], k[2:0], 1'b0);
      if (k == abort_at) begin
        #2 rst = 1'b1;
        #1 check_cycle(sel, "async_rst", 15'h0FE3, 3'd0, 1'b0);
        @(posedge clk); #2;
        check_cycle(sel, "rst_held", 15'h0FE3, 3'd0, 1'b0);
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [3:0] rop;
    rst  = 1'b1;
    rst0 = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 1'b0, 1'b0);
    #12;
    check_cycle(1'b0, "reset1", 15'h0FE3, 3'd0, 1'b0);
    check_cycle(1'b1, "reset0", 15'h0FE3, 3'd0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Directed instruction set walk
    run_instr(1'b0, OP_LDA, 1'b0, 1'b0, -1);
    run_instr(1'b0, OP_ADD, 1'b0, 1'b0, -1);
    run_instr(1'b0, OP_SUB, 1'b1, 1'b1, -1);
    run_instr(1'b0, OP_JC,  1'b0, 1'b1, -1);
    run_instr(1'b0, OP_JC,  1'b1, 1'b0, -1);
    run_instr(1'b0, OP_JZ,  1'b0, 1'b1, -1);
    run_instr(1'b0, OP_JZ,  1'b1, 1'b0, -1);
    run_instr(1'b0, OP_STA, 1'b0, 1'b0, -1);
    run_instr(1'b0, OP_OUT, 1'b0, 1'b0, -1);
    run_instr(1'b0, OP_NOP, 1'b0, 1'b0, -1);
    run_instr(1'b0, OP_LDI, 1'b0, 1'b0, -1);
    run_instr(1'b0, OP_JMP, 1'b0, 1'b0, -1);
    run_instr(1'b0, 4'hA,   1'b0, 1'b0, -1);

    // Asynchronous reset in T3 of LDA, then restart from fetch
    run_instr(1'b0, OP_LDA, 1'b0, 1'b0, 3);
    run_instr(1'b0, OP_LDA, 1'b1, 1'b0, -1);

    // Random instruction stream (no HLT on the halting instance)
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 14));
      run_instr(1'b0, rop, 1'($urandom), 1'($urandom), -1);
    end

    // HLT: parks in T2 with idle word until reset
    run_instr(1'b0, OP_HLT, 1'b0, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 4'($urandom), 1'($urandom), 1'($urandom));
      #1 check_cycle(1'b0, $sformatf("halt_c%0d", i), 15'h0FE3, 3'd2, 1'b1);
      @(posedge clk); #1;
    end
    #1 rst = 1'b1;
    #1 check_cycle(1'b0, "halt_rst", 15'h0FE3, 3'd0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    run_instr(1'b0, OP_ADD, 1'b0, 1'b0, -1);
    run_instr(1'b0, OP_NOP, 1'b0, 1'b0, -1);

    // HLT_ENABLE=0: opcode 0xF is a 3-cycle NOP
    @(posedge clk); #2;
    rst0 = 1'b0;
    run_instr(1'b1, OP_HLT, 1'b0, 1'b0, -1);
    run_instr(1'b1, OP_LDA, 1'b0, 1'b0, -1);
    for (int i = 0; i < 12; i++) begin
      rop = 4'($urandom_range(0, 15));
      run_instr(1'b1, rop, 1'($urandom), 1'($urandom), -1);
    end
    run_instr(1'b1, OP_NOP, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
